// File: rtl/gray_conv_pkg.sv
// Shared types and chunk-boundary helpers for the pipelined Gray/binary converter.
// Each stage resolves one MSB-first chunk of the Gray-to-binary prefix XOR.
package gray_conv_pkg;

  typedef enum logic {
    MODE_G2B = 1'b0,
    MODE_B2G = 1'b1
  } conv_mode_e;

  function automatic int chunk_size(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Highest bit handled by stage s; negative when the stage has nothing left to resolve.
  function automatic int chunk_hi(input int s, input int width, input int stages);
    return width - 1 - s * chunk_size(width, stages);
  endfunction

  function automatic int chunk_lo(input int s, input int width, input int stages);
    int lo;
    lo = width - (s + 1) * chunk_size(width, stages);
    return (lo < 0) ? 0 : lo;
  endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// One pipeline register stage of the converter, including the Gray-to-binary
// XOR chain for the chunk of bits owned by stage index IDX.
module gray_conv_stage
  import gray_conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 4,
  parameter int IDX        = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  in_valid,
  input  logic                  in_mode,
  input  logic                  in_carry,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_mode,
  output logic                  out_carry,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int HI = chunk_hi(IDX, DATA_WIDTH, STAGES);
  localparam int LO = chunk_lo(IDX, DATA_WIDTH, STAGES);

  typedef struct packed {
    logic                  valid;
    conv_mode_e            mode;
    logic                  carry;
    logic [DATA_WIDTH-1:0] data;
  } payload_t;

  payload_t              stage_reg;
  payload_t              stage_next;
  logic [DATA_WIDTH-1:0] resolved;
  logic                  running;

  // Prefix XOR over [HI:LO], seeded with the binary bit just above this chunk.
  always_comb begin
    resolved = in_data;
    running  = in_carry;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (i <= HI && i >= LO) begin
        running     = running ^ in_data[i];
        resolved[i] = running;
      end
    end
  end

  always_comb begin
    stage_next.valid = in_valid;
    stage_next.mode  = conv_mode_e'(in_mode);
    stage_next.carry = in_carry;
    stage_next.data  = in_data;
    if (conv_mode_e'(in_mode) == MODE_G2B) begin
      stage_next.carry = running;
      stage_next.data  = resolved;
    end
  end

  // Payload only loads with a real word so out_data holds its value across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_reg <= '0;
    end else if (advance) begin
      if (in_valid) begin
        stage_reg <= stage_next;
      end else begin
        stage_reg.valid <= 1'b0;
      end
    end
  end

  assign out_valid = stage_reg.valid;
  assign out_mode  = stage_reg.mode;
  assign out_carry = stage_reg.carry;
  assign out_data  = stage_reg.data;

endmodule

// File: rtl/gray_code_conv_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready on both sides.
// The top owns the ready chain and the binary-to-Gray pre-encode; stages do the rest.
module gray_code_conv_pipe
  import gray_conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_mode,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [STAGES:0]       chain_valid;
  logic [STAGES:0]       chain_mode;
  logic [STAGES:0]       chain_carry;
  logic [DATA_WIDTH-1:0] chain_data [STAGES+1];
  logic [STAGES-1:0]     advance;
  logic                  unused_tail_carry;

  assign chain_valid[0] = in_valid;
  assign chain_mode[0]  = in_mode;
  assign chain_carry[0] = 1'b0;
  assign chain_data[0]  = (conv_mode_e'(in_mode) == MODE_B2G) ? (in_data ^ (in_data >> 1)) : in_data;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // A stage moves when any stage at or after it is empty, or the sink takes a word;
      // written as a flat reduction so there is no combinational chain through advance.
      assign advance[gi] = out_ready | ~(&chain_valid[STAGES:gi+1]);

      gray_conv_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .STAGES    (STAGES),
        .IDX       (gi)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .advance  (advance[gi]),
        .in_valid (chain_valid[gi]),
        .in_mode  (chain_mode[gi]),
        .in_carry (chain_carry[gi]),
        .in_data  (chain_data[gi]),
        .out_valid(chain_valid[gi+1]),
        .out_mode (chain_mode[gi+1]),
        .out_carry(chain_carry[gi+1]),
        .out_data (chain_data[gi+1])
      );
    end
  endgenerate

  assign unused_tail_carry = chain_carry[STAGES];

  assign in_ready  = advance[0];
  assign out_valid = chain_valid[STAGES];
  assign out_mode  = chain_mode[STAGES];
  assign out_data  = chain_data[STAGES];

endmodule
